// File: rtl/v_rf_pkg.sv
// Shared types and decode helpers for the sequenced vector register file.
package v_rf_pkg;

  typedef enum logic [1:0] {
    SEW_8   = 2'b00,
    SEW_16  = 2'b01,
    SEW_32  = 2'b10,
    SEW_RSV = 2'b11
  } sew_e;

  typedef enum logic [2:0] {
    LMUL_1 = 3'b000,
    LMUL_2 = 3'b001,
    LMUL_4 = 3'b010,
    LMUL_8 = 3'b011
  } lmul_e;

  typedef enum logic {
    GRP_IDLE  = 1'b0,
    GRP_BURST = 1'b1
  } grp_state_e;

  // Group size in registers; reserved codes decode to 1, result clamped to max_n.
  function automatic int unsigned lmul_to_n(input logic [2:0] code, input int unsigned max_n);
    int unsigned n;
    case (code)
      LMUL_2:  n = 2;
      LMUL_4:  n = 4;
      LMUL_8:  n = 8;
      default: n = 1;
    endcase
    return (n > max_n) ? max_n : n;
  endfunction

  // Element width in bytes; the reserved encoding behaves as 8-bit.
  function automatic int unsigned sew_bytes(input sew_e s);
    int unsigned b;
    case (s)
      SEW_16:  b = 2;
      SEW_32:  b = 4;
      default: b = 1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/v_rf_group_seq.sv
// Group-write sequencer: walks an LMUL register group one register per accepted beat.
module v_rf_group_seq
  import v_rf_pkg::*;
#(
  parameter int unsigned NREGS    = 32,
  parameter int unsigned MAX_LMUL = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           beat,
  input  logic [$clog2(NREGS)-1:0]       wr_addr,
  input  logic [2:0]                     wr_lmul,
  output logic [$clog2(NREGS)-1:0]       tgt_c,
  output logic                           last_c,
  output logic                           misalign_c,
  output logic [$clog2(NREGS)-1:0]       grp_base_c,
  output logic [$clog2(MAX_LMUL+1)-1:0]  grp_n_c
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned NW = $clog2(MAX_LMUL + 1);

  grp_state_e      state;
  logic [AW-1:0]   base;
  logic [NW-1:0]   n;
  logic [NW-1:0]   cnt;
  logic [NW-1:0]   n_new;
  logic [AW-1:0]   amask;
  logic [AW-1:0]   base_new;

  // First beat decodes from the ports; later beats use the latched group.
  always_comb begin
    n_new      = NW'(lmul_to_n(wr_lmul, MAX_LMUL));
    amask      = AW'(n_new - NW'(1));
    base_new   = wr_addr & ~amask;
    tgt_c      = base_new;
    grp_base_c = base_new;
    grp_n_c    = n_new;
    last_c     = beat && (n_new == NW'(1));
    misalign_c = beat && ((wr_addr & amask) != '0);
    if (state == GRP_BURST) begin
      tgt_c      = base + AW'(cnt);
      grp_base_c = base;
      grp_n_c    = n;
      last_c     = beat && (cnt == n - NW'(1));
      misalign_c = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= GRP_IDLE;
      base  <= '0;
      n     <= NW'(1);
      cnt   <= '0;
    end else if (beat) begin
      if (state == GRP_IDLE) begin
        base <= base_new;
        n    <= n_new;
        if (n_new != NW'(1)) begin
          cnt   <= NW'(1);
          state <= GRP_BURST;
        end
      end else if (last_c) begin
        cnt   <= '0;
        state <= GRP_IDLE;
      end else begin
        cnt <= cnt + NW'(1);
      end
    end
  end

endmodule

// File: rtl/v_regfile_seq.sv
// Vector register file with sequenced group writes, SEW element port and busy scoreboard.
module v_regfile_seq
  import v_rf_pkg::*;
#(
  parameter int unsigned VLEN     = 128,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ELEN     = 32,
  parameter int unsigned MAX_LMUL = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NREGS)-1:0]      wr_addr,
  input  logic [2:0]                    wr_lmul,
  input  logic [VLEN-1:0]               wr_data,
  input  logic [VLEN/8-1:0]             wr_be,
  input  logic                          el_wr_en,
  input  logic [$clog2(NREGS)-1:0]      el_wr_reg,
  input  logic [$clog2(VLEN/8)-1:0]     el_wr_idx,
  input  logic [ELEN-1:0]               el_wr_data,
  input  logic [1:0]                    sew,
  input  logic [$clog2(NREGS)-1:0]      el_rd_reg,
  input  logic [$clog2(VLEN/8)-1:0]     el_rd_idx,
  output logic [ELEN-1:0]               el_rd_data,
  input  logic [$clog2(NREGS)-1:0]      rd_addr_a,
  input  logic [$clog2(NREGS)-1:0]      rd_addr_b,
  output logic [VLEN-1:0]               rd_data_a,
  output logic [VLEN-1:0]               rd_data_b,
  output logic [VLEN-1:0]               mask,
  input  logic                          rsv_set,
  input  logic [$clog2(NREGS)-1:0]      rsv_addr,
  input  logic [2:0]                    rsv_lmul,
  output logic [NREGS-1:0]              busy,
  output logic                          err
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned BW = VLEN / 8;
  localparam int unsigned IW = $clog2(BW);
  localparam int unsigned OW = IW + 3;
  localparam int unsigned EB = ELEN / 8;
  localparam int unsigned NW = $clog2(MAX_LMUL + 1);

  logic [VLEN-1:0] regs [NREGS];

  logic            beat;
  logic [AW-1:0]   tgt_c;
  logic            last_c;
  logic            misalign_c;
  logic [AW-1:0]   grp_base_c;
  logic [NW-1:0]   grp_n_c;

  assign wr_ready  = !el_wr_en;
  assign beat      = wr_valid && wr_ready;
  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
  assign mask      = regs[0];

  v_rf_group_seq #(
    .NREGS    (NREGS),
    .MAX_LMUL (MAX_LMUL)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .beat       (beat),
    .wr_addr    (wr_addr),
    .wr_lmul    (wr_lmul),
    .tgt_c      (tgt_c),
    .last_c     (last_c),
    .misalign_c (misalign_c),
    .grp_base_c (grp_base_c),
    .grp_n_c    (grp_n_c)
  );

  logic [2:0]      el_sb;
  logic [EB-1:0]   el_bmask;
  logic [ELEN-1:0] el_emask;
  logic [OW-1:0]   wr_off;
  logic [OW-1:0]   rd_off;
  logic            wr_in_rng;
  logic            rd_in_rng;
  logic [VLEN-1:0] rd_shift;

  // Element addressing: byte offset = idx * SEW bytes, valid while the element fits.
  always_comb begin
    el_sb    = 3'(sew_bytes(sew_e'(sew)));
    el_bmask = '0;
    el_emask = '0;
    for (int b = 0; b < int'(EB); b++) begin
      el_bmask[b]       = (3'(b) < el_sb);
      el_emask[b*8 +: 8] = {8{el_bmask[b]}};
    end
    wr_off     = OW'(el_wr_idx) * OW'(el_sb);
    rd_off     = OW'(el_rd_idx) * OW'(el_sb);
    wr_in_rng  = (wr_off + OW'(el_sb)) <= OW'(BW);
    rd_in_rng  = (rd_off + OW'(el_sb)) <= OW'(BW);
    rd_shift   = regs[el_rd_reg] >> {rd_off, 3'b000};
    el_rd_data = rd_in_rng ? (rd_shift[ELEN-1:0] & el_emask) : '0;
  end

  logic [AW-1:0]   wsel_reg;
  logic [VLEN-1:0] wsel_data;
  logic [BW-1:0]   wsel_be;

  // Element write wins the single write port; a stalled beat waits on wr_ready.
  always_comb begin
    wsel_reg  = tgt_c;
    wsel_data = wr_data;
    wsel_be   = '0;
    if (el_wr_en) begin
      wsel_reg  = el_wr_reg;
      wsel_data = VLEN'(el_wr_data) << {wr_off, 3'b000};
      wsel_be   = wr_in_rng ? (BW'(el_bmask) << wr_off) : '0;
    end else if (beat) begin
      wsel_be = wr_be;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else begin
      for (int b = 0; b < int'(BW); b++) begin
        if (wsel_be[b]) regs[wsel_reg][b*8 +: 8] <= wsel_data[b*8 +: 8];
      end
    end
  end

  logic [NW-1:0]    rsv_n;
  logic [AW-1:0]    rsv_amask;
  logic [AW-1:0]    rsv_base;
  logic [AW-1:0]    clr_amask;
  logic [NREGS-1:0] set_v;
  logic [NREGS-1:0] clr_v;

  // Groups are aligned powers of two, so membership is a masked compare.
  always_comb begin
    rsv_n     = NW'(lmul_to_n(rsv_lmul, MAX_LMUL));
    rsv_amask = AW'(rsv_n - NW'(1));
    rsv_base  = rsv_addr & ~rsv_amask;
    clr_amask = AW'(grp_n_c - NW'(1));
    set_v     = '0;
    clr_v     = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      set_v[i] = rsv_set && ((AW'(i) & ~rsv_amask) == rsv_base);
      clr_v[i] = last_c && ((AW'(i) & ~clr_amask) == grp_base_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= (busy & ~clr_v) | set_v;
      err  <= misalign_c | (el_wr_en & ~wr_in_rng);
    end
  end

endmodule

// File: tb/tb_v_regfile_seq.sv
// Directed bench for v_regfile_seq with hand-computed expectations.
module tb_v_regfile_seq;

  localparam logic [15:0] ALL = 16'hFFFF;

  logic         clk;
  logic         rst;
  logic         wr_valid;
  logic         wr_ready;
  logic [4:0]   wr_addr;
  logic [2:0]   wr_lmul;
  logic [127:0] wr_data;
  logic [15:0]  wr_be;
  logic         el_wr_en;
  logic [4:0]   el_wr_reg;
  logic [3:0]   el_wr_idx;
  logic [31:0]  el_wr_data;
  logic [1:0]   sew;
  logic [4:0]   el_rd_reg;
  logic [3:0]   el_rd_idx;
  logic [31:0]  el_rd_data;
  logic [4:0]   rd_addr_a;
  logic [4:0]   rd_addr_b;
  logic [127:0] rd_data_a;
  logic [127:0] rd_data_b;
  logic [127:0] mask;
  logic         rsv_set;
  logic [4:0]   rsv_addr;
  logic [2:0]   rsv_lmul;
  logic [31:0]  busy;
  logic         err;

  int unsigned  n_pass;
  int unsigned  n_chk;
  logic [127:0] d;

  v_regfile_seq dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_lmul    (wr_lmul),
    .wr_data    (wr_data),
    .wr_be      (wr_be),
    .el_wr_en   (el_wr_en),
    .el_wr_reg  (el_wr_reg),
    .el_wr_idx  (el_wr_idx),
    .el_wr_data (el_wr_data),
    .sew        (sew),
    .el_rd_reg  (el_rd_reg),
    .el_rd_idx  (el_rd_idx),
    .el_rd_data (el_rd_data),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .mask       (mask),
    .rsv_set    (rsv_set),
    .rsv_addr   (rsv_addr),
    .rsv_lmul   (rsv_lmul),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    wr_valid = 0; wr_addr = 0; wr_lmul = 0; wr_data = '0; wr_be = '0;
    el_wr_en = 0; el_wr_reg = 0; el_wr_idx = 0; el_wr_data = 0; sew = 0;
    el_rd_reg = 0; el_rd_idx = 0; rd_addr_a = 0; rd_addr_b = 0;
    rsv_set = 0; rsv_addr = 0; rsv_lmul = 0;
  endtask

  task automatic beat(input logic [4:0] a, input logic [2:0] l, input logic [127:0] dd,
                      input logic [15:0] be);
    wr_valid = 1; wr_addr = a; wr_lmul = l; wr_data = dd; wr_be = be;
    tick();
    wr_valid = 0;
  endtask

  task automatic peek(input logic [4:0] a);
    rd_addr_b = a;
    #1;
    d = rd_data_b;
  endtask

  task automatic test_reset();
    rst = 1; clr_in();
    repeat (2) tick();
    rst = 0;
    tick();
    n_chk++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    n_chk++; if (busy !== 32'h0) $display("FAIL reset_busy: got %h want 0", busy); else n_pass++;
    n_chk++; if (wr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", wr_ready); else n_pass++;
    n_chk++; if (mask !== 128'h0) $display("FAIL reset_mask: got %h want 0", mask); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    beat(5'd1, 3'b000, {16{8'h5C}}, ALL);
    rsv_set = 1; rsv_addr = 5'd16; rsv_lmul = 3'b000;
    tick();
    rsv_set = 0;
    n_chk++; if (busy !== 32'h0001_0000) $display("FAIL mid_rsv_busy: got %h want 00010000", busy); else n_pass++;
    beat(5'd8, 3'b010, {16{8'hC8}}, ALL);
    peek(5'd8);
    n_chk++; if (d !== {16{8'hC8}}) $display("FAIL mid_beat1: got %h want c8..", d); else n_pass++;
    #1 rst = 1;
    #2 rst = 0;
    peek(5'd8);
    n_chk++; if (d !== 128'h0) $display("FAIL mid_v8_clr: got %h want 0", d); else n_pass++;
    peek(5'd1);
    n_chk++; if (d !== 128'h0) $display("FAIL mid_v1_clr: got %h want 0", d); else n_pass++;
    n_chk++; if (busy !== 32'h0) $display("FAIL mid_busy_clr: got %h want 0", busy); else n_pass++;
    n_chk++; if (wr_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", wr_ready); else n_pass++;
    tick();
    // Back in IDLE: a single beat must land at its own address, not at v8+cnt.
    beat(5'd1, 3'b000, {16{8'h1E}}, ALL);
    peek(5'd1);
    n_chk++; if (d !== {16{8'h1E}}) $display("FAIL mid_idle_v1: got %h want 1e..", d); else n_pass++;
    peek(5'd9);
    n_chk++; if (d !== 128'h0) $display("FAIL mid_idle_v9: got %h want 0", d); else n_pass++;
    tick();
  endtask

  task automatic test_lmul4_gap();
    beat(5'd4, 3'b010, {16{8'h11}}, ALL);
    n_chk++; if (err !== 1'b0) $display("FAIL gap_err: got %b want 0", err); else n_pass++;
    beat(5'd0, 3'b000, {16{8'h22}}, ALL);
    tick();
    beat(5'd0, 3'b000, {16{8'h33}}, ALL);
    beat(5'd0, 3'b000, {16{8'h44}}, ALL);
    for (int i = 0; i < 4; i++) begin
      peek(5'(4 + i));
      n_chk++;
      if (d !== {16{8'(8'h11 * (i + 1))}})
        $display("FAIL gap_v%0d: got %h want %h", 4 + i, d, {16{8'(8'h11 * (i + 1))}});
      else n_pass++;
    end
    peek(5'd8);
    n_chk++; if (d !== 128'h0) $display("FAIL gap_v8: got %h want 0", d); else n_pass++;
    tick();
  endtask

  task automatic test_misaligned();
    beat(5'd5, 3'b001, {16{8'hA5}}, ALL);
    n_chk++; if (err !== 1'b1) $display("FAIL mis_err_pulse: got %b want 1", err); else n_pass++;
    beat(5'd0, 3'b000, {16{8'hB6}}, ALL);
    n_chk++; if (err !== 1'b0) $display("FAIL mis_err_once: got %b want 0", err); else n_pass++;
    peek(5'd4);
    n_chk++; if (d !== {16{8'hA5}}) $display("FAIL mis_v4: got %h want a5..", d); else n_pass++;
    peek(5'd5);
    n_chk++; if (d !== {16{8'hB6}}) $display("FAIL mis_v5: got %h want b6..", d); else n_pass++;
    peek(5'd6);
    n_chk++; if (d !== {16{8'h33}}) $display("FAIL mis_v6: got %h want 33..", d); else n_pass++;
    tick();
    // Reserved lmul code behaves as a single-register group.
    beat(5'd9, 3'b111, {16{8'h9F}}, ALL);
    n_chk++; if (err !== 1'b0) $display("FAIL rsvcode_err: got %b want 0", err); else n_pass++;
    beat(5'd10, 3'b000, {16{8'hAF}}, ALL);
    peek(5'd9);
    n_chk++; if (d !== {16{8'h9F}}) $display("FAIL rsvcode_v9: got %h want 9f..", d); else n_pass++;
    peek(5'd10);
    n_chk++; if (d !== {16{8'hAF}}) $display("FAIL rsvcode_v10: got %h want af..", d); else n_pass++;
    tick();
  endtask

  task automatic test_element();
    beat(5'd3, 3'b000, 128'h0123456789ABCDEF_FEDCBA9876543210, ALL);
    el_wr_en = 1; el_wr_reg = 5'd3; el_wr_idx = 4'd7; sew = 2'b01; el_wr_data = 32'h5555BEEF;
    #1;
    n_chk++; if (wr_ready !== 1'b0) $display("FAIL el_ready_low: got %b want 0", wr_ready); else n_pass++;
    tick();
    el_wr_en = 0;
    n_chk++; if (err !== 1'b0) $display("FAIL el_err_inrange: got %b want 0", err); else n_pass++;
    rd_addr_a = 5'd3;
    #1;
    n_chk++; if (rd_data_a !== 128'hBEEF456789ABCDEF_FEDCBA9876543210)
      $display("FAIL el_wr16: got %h want beef4567..", rd_data_a); else n_pass++;
    el_rd_reg = 5'd3; el_rd_idx = 4'd7; sew = 2'b01; #1;
    n_chk++; if (el_rd_data !== 32'h0000BEEF) $display("FAIL el_rd16_i7: got %h want 0000beef", el_rd_data); else n_pass++;
    el_rd_idx = 4'd0; #1;
    n_chk++; if (el_rd_data !== 32'h00003210) $display("FAIL el_rd16_i0: got %h want 00003210", el_rd_data); else n_pass++;
    el_rd_idx = 4'd3; sew = 2'b10; #1;
    n_chk++; if (el_rd_data !== 32'hBEEF4567) $display("FAIL el_rd32_i3: got %h want beef4567", el_rd_data); else n_pass++;
    el_rd_idx = 4'd15; sew = 2'b00; #1;
    n_chk++; if (el_rd_data !== 32'h000000BE) $display("FAIL el_rd8_i15: got %h want 000000be", el_rd_data); else n_pass++;
    el_rd_idx = 4'd1; sew = 2'b11; #1;
    n_chk++; if (el_rd_data !== 32'h00000032) $display("FAIL el_rdsew3_i1: got %h want 00000032", el_rd_data); else n_pass++;
    el_rd_idx = 4'd8; sew = 2'b01; #1;
    n_chk++; if (el_rd_data !== 32'h0) $display("FAIL el_rd_oor: got %h want 0", el_rd_data); else n_pass++;
    tick();
    el_wr_en = 1; el_wr_reg = 5'd3; el_wr_idx = 4'd8; sew = 2'b01; el_wr_data = 32'h00001234;
    tick();
    el_wr_en = 0;
    n_chk++; if (err !== 1'b1) $display("FAIL el_err_oor: got %b want 1", err); else n_pass++;
    tick();
    n_chk++; if (err !== 1'b0) $display("FAIL el_err_drop: got %b want 0", err); else n_pass++;
    n_chk++; if (rd_data_a !== 128'hBEEF456789ABCDEF_FEDCBA9876543210)
      $display("FAIL el_oor_nowrite: got %h want beef4567..", rd_data_a); else n_pass++;
    el_wr_en = 1; el_wr_idx = 4'd1; sew = 2'b10; el_wr_data = 32'hCAFEF00D;
    tick();
    el_wr_en = 0;
    n_chk++; if (rd_data_a !== 128'hBEEF456789ABCDEF_CAFEF00D76543210)
      $display("FAIL el_wr32: got %h want ..cafef00d76543210", rd_data_a); else n_pass++;
    tick();
  endtask

  task automatic test_scoreboard();
    rsv_set = 1; rsv_addr = 5'd16; rsv_lmul = 3'b011;
    tick();
    rsv_set = 0;
    n_chk++; if (busy !== 32'h00FF_0000) $display("FAIL sb_set: got %h want 00ff0000", busy); else n_pass++;
    el_wr_en = 1; el_wr_reg = 5'd16; el_wr_idx = 4'd0; sew = 2'b00; el_wr_data = 32'h1;
    tick();
    el_wr_en = 0;
    n_chk++; if (busy !== 32'h00FF_0000) $display("FAIL sb_el_untouched: got %h want 00ff0000", busy); else n_pass++;
    for (int i = 0; i < 7; i++) beat(5'd16, 3'b011, {16{8'(8'hA0 + i)}}, ALL);
    n_chk++; if (busy !== 32'h00FF_0000) $display("FAIL sb_hold: got %h want 00ff0000", busy); else n_pass++;
    beat(5'd16, 3'b011, {16{8'hA7}}, ALL);
    n_chk++; if (busy !== 32'h0) $display("FAIL sb_clear: got %h want 0", busy); else n_pass++;
    peek(5'd16);
    n_chk++; if (d !== {16{8'hA0}}) $display("FAIL sb_v16: got %h want a0..", d); else n_pass++;
    peek(5'd23);
    n_chk++; if (d !== {16{8'hA7}}) $display("FAIL sb_v23: got %h want a7..", d); else n_pass++;
    tick();
    rsv_set = 1; rsv_addr = 5'd21; rsv_lmul = 3'b011;
    tick();
    rsv_set = 0;
    n_chk++; if (busy !== 32'h00FF_0000) $display("FAIL sb_set_align: got %h want 00ff0000", busy); else n_pass++;
    for (int i = 0; i < 7; i++) beat(5'd16, 3'b011, {16{8'(8'hB0 + i)}}, ALL);
    rsv_set = 1; rsv_addr = 5'd16; rsv_lmul = 3'b011;
    beat(5'd16, 3'b011, {16{8'hB7}}, ALL);
    rsv_set = 0;
    n_chk++; if (busy !== 32'h00FF_0000) $display("FAIL sb_set_wins: got %h want 00ff0000", busy); else n_pass++;
    tick();
    n_chk++; if (busy !== 32'h00FF_0000) $display("FAIL sb_set_sticks: got %h want 00ff0000", busy); else n_pass++;
  endtask

  task automatic test_arbitration();
    el_wr_en = 1; el_wr_reg = 5'd2; el_wr_idx = 4'd0; sew = 2'b00; el_wr_data = 32'h5A;
    wr_valid = 1; wr_addr = 5'd2; wr_lmul = 3'b000; wr_data = {16{8'hFF}}; wr_be = ALL;
    #1;
    n_chk++; if (wr_ready !== 1'b0) $display("FAIL arb_ready: got %b want 0", wr_ready); else n_pass++;
    tick();
    el_wr_en = 0; wr_valid = 0;
    peek(5'd2);
    n_chk++; if (d !== 128'h5A) $display("FAIL arb_el_only: got %h want 5a", d); else n_pass++;
    tick();
    beat(5'd2, 3'b000, {16{8'hAA}}, 16'hFFFE);
    peek(5'd2);
    n_chk++; if (d !== {{15{8'hAA}}, 8'h5A}) $display("FAIL be_upper: got %h want aa..5a", d); else n_pass++;
    tick();
    beat(5'd2, 3'b000, {16{8'h77}}, 16'h0001);
    peek(5'd2);
    n_chk++; if (d !== {{15{8'hAA}}, 8'h77}) $display("FAIL be_byte0: got %h want aa..77", d); else n_pass++;
    tick();
  endtask

  task automatic test_no_bypass();
    rd_addr_a = 5'd0;
    wr_valid = 1; wr_addr = 5'd0; wr_lmul = 3'b000; wr_data = {16{8'h0F}}; wr_be = ALL;
    #1;
    n_chk++; if (mask !== 128'h0) $display("FAIL nb_mask_pre: got %h want 0", mask); else n_pass++;
    n_chk++; if (rd_data_a !== 128'h0) $display("FAIL nb_rda_pre: got %h want 0", rd_data_a); else n_pass++;
    tick();
    wr_valid = 0;
    n_chk++; if (mask !== {16{8'h0F}}) $display("FAIL nb_mask_post: got %h want 0f..", mask); else n_pass++;
    n_chk++; if (rd_data_a !== {16{8'h0F}}) $display("FAIL nb_rda_post: got %h want 0f..", rd_data_a); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    test_reset();
    test_reset_mid_burst();
    test_lmul4_gap();
    test_misaligned();
    test_element();
    test_scoreboard();
    test_arbitration();
    test_no_bypass();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/v_regfile_seq.md
Name: v_regfile_seq

Overview:
Parametrised successor of the coprocessor vector register file. Holds NREGS registers of VLEN bits. Adds:
- a sequenced group-write port that commits an LMUL register group one register per beat under valid/ready, with byte enables;
- an SEW-scaled element write/read port;
- a per-register busy scoreboard for the issue stage.
Sits between the vector issue/execute stages and the load/store and ALU write-back paths.

Parameters:
VLEN, 128, register width in bits (multiple of 32)
NREGS, 32, number of vector registers (power of two)
ELEN, 32, maximum element width in bits
MAX_LMUL, 8, largest group size supported (1, 2, 4 or 8)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wr_valid  in  1  group-write beat valid
wr_ready  out  1  group-write beat accepted when valid&ready
wr_addr  in  $clog2(NREGS)  group base register, sampled on first beat only
wr_lmul  in  3  group size code, sampled on first beat only: 000=1, 001=2, 010=4, 011=8, others=1
wr_data  in  VLEN  beat data
wr_be  in  VLEN/8  byte enables for the beat
el_wr_en  in  1  element write strobe
el_wr_reg  in  $clog2(NREGS)  element write target register
el_wr_idx  in  $clog2(VLEN/8)  element index
el_wr_data  in  ELEN  element data, low SEW bits used
sew  in  2  element width: 00=8, 01=16, 10=32, 11 treated as 8
el_rd_reg  in  $clog2(NREGS)  element read register
el_rd_idx  in  $clog2(VLEN/8)  element read index
el_rd_data  out  ELEN  element read, zero-extended
rd_addr_a  in  $clog2(NREGS)  read port A register
rd_addr_b  in  $clog2(NREGS)  read port B register
rd_data_a  out  VLEN  read port A data
rd_data_b  out  VLEN  read port B data
mask  out  VLEN  contents of register 0
rsv_set  in  1  reserve a group
rsv_addr  in  $clog2(NREGS)  reservation base
rsv_lmul  in  3  reservation size code, same encoding as wr_lmul
busy  out  NREGS  scoreboard, bit i = register i has a pending write
err  out  1  one-cycle pulse on misaligned group or out-of-range element index

Behaviour:
- Reset (asynchronous, any cycle including mid-burst): all registers 0, FSM to IDLE, busy=0, err=0, beat counter 0.
- FSM states: IDLE and BURST.
  - IDLE: first accepted beat latches base=wr_addr aligned down to group size, n=clamped group size, and writes beat to base. Goes to BURST if n>1, otherwise stays IDLE.
  - BURST: each accepted beat writes to base+cnt and increments cnt. After beat n-1, returns to IDLE. A wr_valid gap holds state.
- Group size is min(decoded lmul, MAX_LMUL).
- If wr_addr is misaligned (addr mod n != 0), err pulses on the first beat and the aligned-down base is used.
- Write-enable rules:
  - Beats write only bytes with wr_be=1.
  - Writes land at the clock edge; reads are combinational and return pre-write data in the same cycle (no bypass).
- Element port:
  - Byte offset = el_wr_idx*SEW/8.
  - If el_wr_idx >= VLEN/SEW, err pulses and no write occurs.
  - el_rd_data reads the same way; an out-of-range index returns 0.
- Arbitration: el_wr_en has priority. wr_ready = !el_wr_en in both states, so a beat and an element write never commit in the same cycle.
- Scoreboard:
  - rsv_set sets busy for the n registers of the aligned group on the next edge.
  - The last beat of a burst clears busy for the committed group on the next edge.
  - Set and clear of the same bit in one cycle: set wins.
  - Element writes do not touch busy.
- mask always reflects register 0, including pre-write data during a write cycle.

Decomposition:
- Package v_rf_pkg holds:
  - sew_e and lmul_e enums;
  - function lmul_to_n(code, max) returning the clamped group size;
  - function sew_bytes(sew).
- One sub-module, v_rf_group_seq, holds the IDLE/BURST FSM, base/cnt/n registers, alignment check and last-beat pulse. The top level holds the storage, ports, arbitration and scoreboard.

Test Plan:
- Reset mid-burst: start a wr_lmul=010 burst at v8, assert rst after beat 1 -> all registers 0, busy=0, wr_ready=1 and the FSM is IDLE after release.
- LMUL=4 burst at v4 with data 0x11.., 0x22.., 0x33.., 0x44.. and a 1-cycle wr_valid gap after beat 2 -> v4..v7 hold the four values in order, v8 unchanged.
- Misaligned burst: wr_addr=5, lmul=001 -> err pulses once, data lands in v4 and v5.
- Element write: sew=01, v3, idx 7, data 0xBEEF -> rd_data_a(v3)[127:112]=0xBEEF, other bits unchanged. idx 8 -> err, no write.
- Scoreboard: rsv_set v16 lmul=011 -> busy[23:16]=FF. 8-beat burst to v16 -> busy clears the cycle after the last beat. rsv_set of v16 coincident with the last beat -> busy stays set.
- Arbitration and byte enables: el_wr_en and wr_valid in the same cycle -> wr_ready=0 and only the element write commits. A beat with wr_be=0x0001 changes only byte 0.
